// File: rtl/adder_seq_ctrl.sv
// ============================================================================
// Module   : adder_seq_ctrl
// Brief    : Byte-serial NBYTES-wide add/subtract sequencer driving one shared
//            external 8-bit combinational adder, LSB byte first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout
);

    localparam int c_w    = 8 * NBYTES;
    localparam int c_idxw = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_idxw-1:0] c_idx_last = c_idxw'(NBYTES - 1);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_fin  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_idxw-1:0] r_idx;
    logic              r_carry;
    logic [c_w-1:0]    r_a_sh;
    logic [c_w-1:0]    r_b_sh;
    logic              r_sub_sh;
    logic [c_w-1:0]    r_acc;
    logic [c_w-1:0]    r_result;
    logic              r_carry_out;
    logic              r_overflow;
    logic [c_w-1:0]    w_final;
    logic              w_last;

    assign w_last    = (r_idx == c_idx_last);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: if (start) w_state_nxt = c_s_run;
            c_s_run:  if (w_last) w_state_nxt = c_s_fin;
            c_s_fin:  w_state_nxt = c_s_idle;
            default:  w_state_nxt = c_s_idle;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        case (r_state)
            c_s_run: begin
                busy    = 1'b1;
                add_a   = r_a_sh[8*r_idx +: 8];
                add_b   = r_b_sh[8*r_idx +: 8] ^ {8{r_sub_sh}};
                add_cin = r_carry;
            end
            c_s_fin: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator with the byte currently on the adder merged in, so the
    // final edge can publish the whole word at once.
    always_comb begin
        w_final = r_acc;
        w_final[8*r_idx +: 8] = add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sub_sh    <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        r_a_sh   <= op_a;
                        r_b_sh   <= op_b;
                        r_sub_sh <= sub;
                        r_idx    <= '0;
                        r_carry  <= sub;
                    end
                end
                c_s_run: begin
                    r_acc[8*r_idx +: 8] <= add_sum;
                    r_carry             <= add_cout;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_result    <= w_final;
                        r_carry_out <= add_cout;
                        r_overflow  <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
                    end else begin
                        r_idx <= r_idx + c_idxw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
// ============================================================================
// Module   : tb_adder_seq_ctrl
// Brief    : Self-checking bench for adder_seq_ctrl with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_seq_ctrl;

    localparam int NBYTES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, carry_out, overflow;
    logic [31:0] result;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_res = '0;

    always #5 clk = ~clk;

    // The external shared adder: purely combinational
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] r, output logic c, output logic o,
                                  output logic [3:0] cin);
        longint unsigned la, lb, part, m;
        la = {32'h0, a};
        lb = s ? {32'h0, ~b} : {32'h0, b};
        r  = s ? (a - b) : (a + b);
        c  = s ? (a >= b) : (((la + {32'h0, b}) >> 32) != 0);
        o  = s ? ((a[31] != b[31]) && (r[31] != a[31]))
               : ((a[31] == b[31]) && (r[31] != a[31]));
        cin[0] = s;
        for (int i = 1; i < 4; i++) begin
            m       = (64'd1 << (8 * i)) - 64'd1;
            part    = (la & m) + (lb & m) + {63'h0, s};
            cin[i]  = part[8*i];
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] er;
        logic        ec, eo;
        logic [3:0]  ecin, cins;
        model(a, b, s, er, ec, eo, ecin);
        cins  = '0;
        start = 1'b1; op_a = a; op_b = b; sub = s;
        tick();
        start = 1'b0; op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
        for (int k = 1; k <= NBYTES + 1; k++) begin
            chk("busy_run", {63'h0, busy}, 64'd1);
            chk("done_pulse", {63'h0, done}, {63'h0, (k == NBYTES + 1)});
            if (k <= NBYTES) begin
                cins[k-1] = add_cin;
                chk("result_held", {32'h0, result}, {32'h0, prev_res});
            end else begin
                chk("result", {32'h0, result}, {32'h0, er});
                chk("carry_out", {63'h0, carry_out}, {63'h0, ec});
                chk("overflow", {63'h0, overflow}, {63'h0, eo});
                chk("cin_seq", {60'h0, cins}, {60'h0, ecin});
            end
            tick();
        end
        chk("busy_after", {63'h0, busy}, 64'd0);
        chk("done_after", {63'h0, done}, 64'd0);
        prev_res = er;
    endtask

    logic [31:0] ha [0:17];
    logic [31:0] hb [0:17];
    logic        hs [0:17];

    initial begin
        logic [31:0] er;
        logic        ec, eo;
        logic [3:0]  ecin;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_result", {32'h0, result}, 64'd0);
        chk("rst_flags", {62'h0, carry_out, overflow}, 64'd0);
        chk("rst_adder", {47'h0, add_a, add_b, add_cin}, 64'd0);
        start = 1'b1;
        tick();
        chk("rst_beats_start", {63'h0, busy}, 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        run_op(32'h000000FF, 32'h00000001, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        run_op(32'd5, 32'd7, 1'b1);
        run_op(32'd7, 32'd5, 1'b1);
        run_op(32'h80000000, 32'h00000001, 1'b1);

        // Reset in the RUN cycle working on byte 2
        start = 1'b1; op_a = 32'h12345678; op_b = 32'h11111111; sub = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {63'h0, busy}, 64'd0);
        chk("midrst_result", {32'h0, result}, 64'd0);
        chk("midrst_flags", {62'h0, carry_out, overflow}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            chk("midrst_no_done", {63'h0, done}, 64'd0);
            tick();
        end
        prev_res = '0;
        run_op(32'h12345678, 32'h11111111, 1'b0);

        // start held high, operands changing every cycle
        for (int j = 0; j < 18; j++) begin
            ha[j] = $urandom; hb[j] = $urandom; hs[j] = 1'($urandom);
            start = 1'b1; op_a = ha[j]; op_b = hb[j]; sub = hs[j];
            chk("held_busy", {63'h0, busy}, {63'h0, ((j % 6) != 0)});
            chk("held_done", {63'h0, done}, {63'h0, ((j % 6) == 5)});
            if ((j % 6) == 5) begin
                model(ha[j-5], hb[j-5], hs[j-5], er, ec, eo, ecin);
                chk("held_result", {32'h0, result}, {32'h0, er});
                chk("held_flags", {62'h0, carry_out, overflow}, {62'h0, ec, eo});
                prev_res = er;
            end
            tick();
        end
        start = 1'b0;
        chk("held_idle_busy", {63'h0, busy}, 64'd0);
        tick();
        chk("held_stays_idle", {63'h0, busy}, 64'd0);

        for (int n = 0; n < 20; n++) begin
            run_op($urandom, $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer that reuses the shared combinational 8-bit ripple adder to perform NBYTES-wide add/subtract, one byte per clock, LSB first.
- Chains carry between bytes through an internal carry register.
- Sits between the PS GPIO operand registers and the single adder instance; result and flags are returned to a GPIO input channel.
- Owns the adder's A/B/Cin inputs exclusively while running.

Parameters:
NBYTES, 4, operand width in bytes (>=1); total width W = 8*NBYTES.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only in IDLE
sub  input  1  0 = A+B, 1 = A-B; sampled with start
op_a  input  W  operand A; sampled with start
op_b  input  W  operand B; sampled with start
busy  output  1  high from cycle after accepted start through done cycle inclusive
done  output  1  one-cycle pulse; result/flags valid
result  output  W  final sum/difference; held until next completion
carry_out  output  1  carry out of MSB byte (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow of W-bit op
add_a  output  8  to adder A
add_b  output  8  to adder B (B byte, inverted when sub)
add_cin  output  1  to adder Cin
add_sum  input  8  from adder S
add_cout  input  1  from adder Cout

Behaviour:
- Reset:
  - State IDLE.
  - busy=0, done=0, result=0, carry_out=0, overflow=0.
  - add_a=0, add_b=0, add_cin=0.
  - Internal byte index and carry register cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - Adder inputs driven to 0.
  - start=1 at edge T: capture op_a, op_b and sub into shadow registers.
  - At the same edge: idx<=0, carry_reg<=sub, go to RUN.
- RUN:
  - Combinational drive:
    - add_a = a_sh[8*idx +: 8].
    - add_b = b_sh[8*idx +: 8], XOR {8{sub_sh}}.
    - add_cin = carry_reg.
  - At each edge: acc[8*idx +: 8]<=add_sum; carry_reg<=add_cout; idx<=idx+1.
  - When idx==NBYTES-1, that edge also:
    - result<=acc with top byte = add_sum.
    - carry_out<=add_cout.
    - overflow<=(add_a[7]==add_b[7]) && (add_sum[7]!=add_a[7]).
    - Go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T, so done is high in the cycle after edge T+NBYTES, i.e. NBYTES+1 cycles after the start cycle.
- Throughput: a new start may be accepted in the cycle following FIN.
- start asserted while busy is ignored. No queuing and no effect on the in-flight operation.
- Operand changes after capture have no effect on the in-flight operation.
- result, carry_out and overflow change only at the final RUN edge; they are stable otherwise, including during a subsequent run.
- Wrap-around: arithmetic is modulo 2^W. idx never exceeds NBYTES-1.
- NBYTES=1: one RUN cycle; behaves as a registered single adder.
- rst asserted mid-RUN or in FIN:
  - Next state IDLE, all outputs to reset values, no done pulse.
  - Operation is discarded.
- rst and start in the same cycle: rst wins.
- The adder is pure combinational. The block adds no register between add_* outputs and add_sum/add_cout inputs.

Test Plan:
- NBYTES=4, A=0x000000FF, B=0x00000001, sub=0 -> done at start+5 cycles; result=0x00000100, carry_out=0, overflow=0; busy high exactly 5 cycles.
- A=0xFFFFFFFF, B=0x00000001, add -> result=0x00000000, carry_out=1, overflow=0; add_cin observed 0,1,1,1 across RUN cycles.
- A=0x7FFFFFFF, B=0x00000001, add -> result=0x80000000, overflow=1, carry_out=0.
- A=5, B=7, sub=1 -> result=0xFFFFFFFE, carry_out=0, overflow=0. Then A=7, B=5, sub=1 -> result=0x00000002, carry_out=1.
- Start held high continuously with operands changed every cycle -> each op uses values from its accepted-start cycle; done pulses every NBYTES+2 cycles; no start accepted while busy.
- Assert rst for one cycle at RUN idx=2 -> next cycle busy=0, result=0, no done pulse. A following start completes normally with correct result.
